// File: rtl/imager_seq_pkg.sv
// rtl/imager_seq_pkg.sv - state encoding, status codes and default parameters for the exposure sequencer
package imager_seq_pkg;

    localparam int DEF_NUM_ROWS   = 160;
    localparam int DEF_MASK_DES_L = 18;
    localparam int DEF_EXP_UNIT   = 100;
    localparam int DEF_TAIL_CYC   = 2;
    localparam int DEF_CNT_W      = 32;

    localparam logic [7:0] STAT_RESET = 8'hAA;

    typedef enum logic [6:0] {
        S_IDLE       = 7'b000_0001,
        S_LOAD_FIRST = 7'b000_0010,
        S_LOAD_N     = 7'b000_0100,
        S_EXP        = 7'b000_1000,
        S_LOAD_LAST  = 7'b001_0000,
        S_ADC_REQ    = 7'b010_0000,
        S_ADC_WAIT   = 7'b100_0000
    } state_t;

    function automatic logic [7:0] stat_code(input state_t s);
        case (s)
            S_IDLE:       stat_code = 8'hF0;
            S_LOAD_FIRST: stat_code = 8'hFE;
            S_LOAD_N:     stat_code = 8'hFD;
            S_EXP:        stat_code = 8'hFC;
            S_LOAD_LAST:  stat_code = 8'hFB;
            S_ADC_REQ:    stat_code = 8'hFA;
            S_ADC_WAIT:   stat_code = 8'hF8;
            default:      stat_code = 8'hF0;
        endcase
    endfunction

endpackage

// File: rtl/imager_exp_seq_if.sv
// rtl/imager_exp_seq_if.sv - FSMIND handshake between the exposure sequencer and the ADC readout FSM
interface imager_exp_seq_if;
    logic FSMIND0;
    logic FSMIND0ACK;
    logic FSMIND1;
    logic FSMIND1ACK;

    modport master (input FSMIND0, FSMIND1ACK, output FSMIND1, FSMIND0ACK);
    modport slave  (output FSMIND0, FSMIND1ACK, input FSMIND1, FSMIND0ACK);
endinterface

// File: rtl/mask_load_ctr.sv
// rtl/mask_load_ctr.sv - row counter for one mask load: STREAM for NUM_ROWS rows, then TAIL_CYC flush cycles
module mask_load_ctr
    import imager_seq_pkg::*;
#(
    parameter int NUM_ROWS = DEF_NUM_ROWS,
    parameter int TAIL_CYC = DEF_TAIL_CYC
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_run,
    input  logic i_abort,
    output logic o_stream,
    output logic o_en,
    output logic o_last
);
    localparam int LAST_R = NUM_ROWS + TAIL_CYC;
    localparam int R_W    = $clog2(LAST_R + 1);

    logic [R_W-1:0] r_row;
    logic           r_stream;
    logic           r_en;

    // Final cycle of the load: the owning FSM advances on this same edge.
    assign o_last   = i_run && (r_row == R_W'(LAST_R));
    assign o_stream = r_stream;
    assign o_en     = r_en;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_row    <= '0;
            r_stream <= 1'b0;
            r_en     <= 1'b0;
        end else if (i_abort || !i_run) begin
            r_row    <= '0;
            r_stream <= 1'b0;
            r_en     <= 1'b0;
        end else if (r_row < R_W'(NUM_ROWS)) begin
            r_stream <= 1'b1;
            r_en     <= 1'b1;
            r_row    <= r_row + R_W'(1);
        end else if (r_row < R_W'(LAST_R)) begin
            r_stream <= 1'b0;
            r_row    <= r_row + R_W'(1);
        end else begin
            r_en  <= 1'b0;
            r_row <= '0;
        end
    end

endmodule

// File: rtl/imager_exp_seq.sv
// rtl/imager_exp_seq.sv - per-frame pixel reset, mask pre-load, subscene exposure and ADC hand-off sequencer
module imager_exp_seq
    import imager_seq_pkg::*;
#(
    parameter int NUM_ROWS   = DEF_NUM_ROWS,
    parameter int MASK_DES_L = DEF_MASK_DES_L,
    parameter int EXP_UNIT   = DEF_EXP_UNIT,
    parameter int TAIL_CYC   = DEF_TAIL_CYC,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic             CLKMPRE,
    input  logic             RESET_B,
    input  logic             ENABLE,
    input  logic             CONT,
    input  logic             ABORT,
    input  logic [CNT_W-1:0] Exp_subc,
    input  logic [CNT_W-1:0] Num_Pat,
    imager_exp_seq_if.master adc,
    output logic             OK_PIXRES_GLOB,
    output logic             CLKMPRE_EN,
    output logic             STREAM,
    output logic             OK_DRAIN_B,
    output logic             FRAME_DONE,
    output logic             BUSY,
    output logic [CNT_W-1:0] CntSubc,
    output logic [CNT_W-1:0] FrameCnt,
    output logic [7:0]       fsm_stat
);
    localparam int PW = CNT_W + 7;
    localparam int AW = CNT_W + 8;

    state_t           r_state;
    logic [7:0]       r_fsm_stat;
    logic             r_pixres;
    logic             r_drain_b;
    logic             r_fsmind1;
    logic             r_fsmind0ack;
    logic             r_frame_done;
    logic             r_busy;
    logic [CNT_W-1:0] r_cnt_subc;
    logic [CNT_W-1:0] r_frame_cnt;
    logic             r_cont_lat;
    logic [CNT_W-1:0] r_exp_lat;
    logic [CNT_W-1:0] r_np_eff;
    logic [AW-1:0]    r_acc;

    logic             w_load;
    logic             w_last;
    logic [PW-1:0]    w_prod;
    logic [CNT_W-1:0] w_np_in;

    assign w_load  = (r_state == S_LOAD_FIRST) || (r_state == S_LOAD_N) || (r_state == S_LOAD_LAST);
    // Full-width product so the largest exposure setting never wraps.
    assign w_prod  = PW'(r_exp_lat) * PW'(EXP_UNIT);
    assign w_np_in = (Num_Pat == '0) ? CNT_W'(1) : Num_Pat;

    mask_load_ctr #(
        .NUM_ROWS (NUM_ROWS),
        .TAIL_CYC (TAIL_CYC)
    ) u_mask_load_ctr (
        .clk      (CLKMPRE),
        .resetn   (RESET_B),
        .i_run    (w_load),
        .i_abort  (ABORT),
        .o_stream (STREAM),
        .o_en     (CLKMPRE_EN),
        .o_last   (w_last)
    );

    always_ff @(posedge CLKMPRE) begin
        if (!RESET_B) begin
            r_state      <= S_IDLE;
            r_fsm_stat   <= STAT_RESET;
            r_pixres     <= 1'b1;
            r_drain_b    <= 1'b0;
            r_fsmind1    <= 1'b0;
            r_fsmind0ack <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
            r_cnt_subc   <= '0;
            r_frame_cnt  <= '0;
            r_cont_lat   <= 1'b0;
            r_exp_lat    <= '0;
            r_np_eff     <= '0;
            r_acc        <= '0;
        end else if (ABORT) begin
            r_state      <= S_IDLE;
            r_fsm_stat   <= stat_code(S_IDLE);
            r_pixres     <= 1'b1;
            r_drain_b    <= 1'b0;
            r_fsmind1    <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_fsm_stat   <= stat_code(r_state);
            case (r_state)
                S_IDLE: begin
                    r_pixres  <= 1'b1;
                    r_drain_b <= 1'b0;
                    if (ENABLE) begin
                        r_cont_lat <= CONT;
                        r_exp_lat  <= Exp_subc;
                        r_np_eff   <= w_np_in;
                        r_cnt_subc <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= S_LOAD_FIRST;
                        r_fsm_stat <= stat_code(S_LOAD_FIRST);
                    end
                end
                S_LOAD_FIRST: begin
                    r_pixres  <= 1'b1;
                    r_drain_b <= 1'b0;
                    if (w_last) begin
                        r_cnt_subc <= CNT_W'(1);
                        r_state    <= S_LOAD_N;
                        r_fsm_stat <= stat_code(S_LOAD_N);
                    end
                end
                S_LOAD_N: begin
                    if (w_last) begin
                        r_cnt_subc <= r_cnt_subc + CNT_W'(1);
                        r_pixres   <= 1'b0;
                        r_drain_b  <= 1'b1;
                        r_acc      <= '0;
                        r_state    <= S_EXP;
                        r_fsm_stat <= stat_code(S_EXP);
                    end
                end
                S_EXP: begin
                    // Exposure measured in mask-clock steps of MASK_DES_L high-speed cycles.
                    if (r_acc <= {1'b0, w_prod}) begin
                        r_acc <= r_acc + AW'(MASK_DES_L);
                    end else if (r_cnt_subc < r_np_eff) begin
                        r_state    <= S_LOAD_N;
                        r_fsm_stat <= stat_code(S_LOAD_N);
                    end else begin
                        r_state    <= S_LOAD_LAST;
                        r_fsm_stat <= stat_code(S_LOAD_LAST);
                    end
                end
                S_LOAD_LAST: begin
                    if (w_last) begin
                        r_drain_b    <= 1'b0;
                        r_pixres     <= 1'b1;
                        r_frame_done <= 1'b1;
                        r_frame_cnt  <= r_frame_cnt + CNT_W'(1);
                        if (r_cont_lat) begin
                            r_cont_lat <= CONT;
                            r_exp_lat  <= Exp_subc;
                            r_np_eff   <= w_np_in;
                            r_cnt_subc <= '0;
                            r_state    <= S_LOAD_FIRST;
                            r_fsm_stat <= stat_code(S_LOAD_FIRST);
                        end else begin
                            r_fsmind1    <= 1'b1;
                            r_fsmind0ack <= 1'b0;
                            r_state      <= S_ADC_REQ;
                            r_fsm_stat   <= stat_code(S_ADC_REQ);
                        end
                    end
                end
                S_ADC_REQ: begin
                    if (adc.FSMIND1ACK) begin
                        r_state    <= S_ADC_WAIT;
                        r_fsm_stat <= stat_code(S_ADC_WAIT);
                    end
                end
                S_ADC_WAIT: begin
                    if (adc.FSMIND0) begin
                        r_fsmind1    <= 1'b0;
                        r_fsmind0ack <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                        r_fsm_stat   <= stat_code(S_IDLE);
                    end
                end
                default: begin
                    r_pixres   <= 1'b1;
                    r_drain_b  <= 1'b0;
                    r_fsmind1  <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                    r_fsm_stat <= stat_code(S_IDLE);
                end
            endcase
        end
    end

    assign OK_PIXRES_GLOB = r_pixres;
    assign OK_DRAIN_B     = r_drain_b;
    assign FRAME_DONE     = r_frame_done;
    assign BUSY           = r_busy;
    assign CntSubc        = r_cnt_subc;
    assign FrameCnt       = r_frame_cnt;
    assign fsm_stat       = r_fsm_stat;
    assign adc.FSMIND1    = r_fsmind1;
    assign adc.FSMIND0ACK = r_fsmind0ack;

endmodule
